// File: rtl/i2c_target_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regs_pkg
//  Description : State encodings, bus levels and helpers for the I2C target.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_target_regs_pkg;

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_ADDR      = 4'd1;
    localparam logic [3:0] c_ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] c_ST_PTR       = 4'd3;
    localparam logic [3:0] c_ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] c_ST_WDATA     = 4'd5;
    localparam logic [3:0] c_ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] c_ST_RDATA     = 4'd7;
    localparam logic [3:0] c_ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] c_ST_IGNORE    = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_ADDR      = c_ST_ADDR,
        ST_ADDR_ACK  = c_ST_ADDR_ACK,
        ST_PTR       = c_ST_PTR,
        ST_PTR_ACK   = c_ST_PTR_ACK,
        ST_WDATA     = c_ST_WDATA,
        ST_WDATA_ACK = c_ST_WDATA_ACK,
        ST_RDATA     = c_ST_RDATA,
        ST_RDATA_ACK = c_ST_RDATA_ACK,
        ST_IGNORE    = c_ST_IGNORE
    } state_t;

    localparam logic       c_ACK_LEVEL  = 1'b0;
    localparam logic       c_NACK_LEVEL = 1'b1;
    localparam int         c_RW_BIT     = 0;
    localparam logic [2:0] c_LAST_BIT   = 3'd7;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regs_if
//  Description : I2C pad levels plus register-file port of the I2C target.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_target_regs_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_low;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       addressed;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_low, reg_addr, reg_wdata, reg_we, busy, addressed
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_low, reg_addr, reg_wdata, reg_we, busy, addressed
    );
endinterface
`default_nettype wire

// File: rtl/i2c_target_regs_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_filter
//  Description : 2-flop synchroniser, glitch filter and edge pulses for one line.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_line,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);
    localparam logic [3:0] c_CNT_LAST = 4'(FILTER_LEN - 1);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= 4'd0;
            r_filt  <= 1'b1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            // Level flips only after FILTER_LEN consecutive differing samples
            if (r_sync[1] == r_filt) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt  <= 4'd0;
                r_filt <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
            r_level <= r_filt;
            r_rise  <= r_filt & ~r_level;
            r_fall  <= ~r_filt & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regs
//  Description : I2C target with 8-bit register pointer driving a register file.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A,
    parameter int         FILTER_LEN  = 4
) (
    input  wire logic        clock,
    input  wire logic        reset,
    i2c_target_regs_if.slave bus
);
    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clock   (clock),
        .reset   (reset),
        .i_line  (bus.scl_in),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clock   (clock),
        .reset   (reset),
        .i_line  (bus.sda_in),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_sda_low;
    logic       r_busy;
    logic       r_addressed;
    logic       r_rw;
    logic       r_phase;        // ACK states: 0 = before ACK slot, 1 = inside/after it
    logic       r_inc_pending;

    logic       w_start;
    logic       w_stop;
    logic       w_last_bit;
    logic [7:0] w_byte;

    assign w_start    = w_sda_fall & w_scl_lvl;
    assign w_stop     = w_sda_rise & w_scl_lvl;
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
    assign w_byte     = {r_shift[6:0], w_sda_lvl};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_reg_addr    <= 8'h00;
            r_reg_wdata   <= 8'h00;
            r_reg_we      <= 1'b0;
            r_sda_low     <= 1'b0;
            r_busy        <= 1'b0;
            r_addressed   <= 1'b0;
            r_rw          <= 1'b0;
            r_phase       <= 1'b0;
            r_inc_pending <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            if (r_inc_pending) begin
                r_reg_addr    <= r_reg_addr + 8'd1;
                r_inc_pending <= 1'b0;
            end

            if (w_stop) begin
                r_state     <= ST_IDLE;
                r_sda_low   <= 1'b0;
                r_busy      <= 1'b0;
                r_addressed <= 1'b0;
            end else if (w_start) begin
                r_state     <= ST_ADDR;
                r_bit_cnt   <= 3'd0;
                r_busy      <= 1'b1;
                r_addressed <= 1'b0;
                r_sda_low   <= 1'b0;
                r_phase     <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (addr_match(w_byte, DEVICE_ADDR)) begin
                                    r_state     <= ST_ADDR_ACK;
                                    r_addressed <= 1'b1;
                                    r_rw        <= w_byte[c_RW_BIT];
                                    r_phase     <= 1'b0;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end

                    // First fall drives the ACK, the second releases it and moves on
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_low <= 1'b1;
                                r_phase   <= 1'b1;
                            end else begin
                                r_sda_low <= 1'b0;
                                r_phase   <= 1'b0;
                                if (r_state == ST_ADDR_ACK && r_rw) begin
                                    r_shift   <= bus.reg_rdata;
                                    r_sda_low <= ~bus.reg_rdata[7];
                                    r_state   <= ST_RDATA;
                                end else if (r_state == ST_ADDR_ACK) begin
                                    r_state <= ST_PTR;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_reg_addr <= w_byte;
                                r_state    <= ST_PTR_ACK;
                                r_phase    <= 1'b0;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_reg_wdata   <= w_byte;
                                r_reg_we      <= 1'b1;
                                r_inc_pending <= 1'b1;
                                r_state       <= ST_WDATA_ACK;
                                r_phase       <= 1'b0;
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_state <= ST_RDATA_ACK;
                                r_phase <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_sda_low <= ~r_shift[7];
                        end
                    end

                    ST_RDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_low <= 1'b0;
                            end else begin
                                r_shift   <= bus.reg_rdata;
                                r_sda_low <= ~bus.reg_rdata[7];
                                r_phase   <= 1'b0;
                                r_state   <= ST_RDATA;
                            end
                        end else if (w_scl_rise && !r_phase) begin
                            if (w_sda_lvl == c_ACK_LEVEL) begin
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_phase    <= 1'b1;
                            end else begin
                                r_state     <= ST_IGNORE;
                                r_addressed <= 1'b0;
                                r_sda_low   <= 1'b0;
                            end
                        end
                    end

                    ST_IGNORE: begin
                        r_sda_low <= 1'b0;
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.sda_low   = r_sda_low;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_we    = r_reg_we;
    assign bus.busy      = r_busy;
    assign bus.addressed = r_addressed;
endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_regs
//  Description : Directed bus-level checks of the I2C target register bridge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_target_regs;
    localparam int c_Q = 50;   // quarter bit period in clocks

    logic clock;
    logic reset;
    logic m_scl;
    logic m_sda;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] we_addr [$];
    logic [7:0] we_data [$];
    logic       sda_low_seen;
    logic       addressed_seen;

    i2c_target_regs_if bus ();

    assign bus.scl_in    = m_scl;
    assign bus.sda_in    = m_sda & ~bus.sda_low;
    assign bus.reg_rdata = mem[bus.reg_addr];

    i2c_target_regs #(.DEVICE_ADDR(7'h1A), .FILTER_LEN(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.reg_we) begin
            we_addr.push_back(bus.reg_addr);
            we_data.push_back(bus.reg_wdata);
        end
        if (bus.sda_low)   sda_low_seen   = 1'b1;
        if (bus.addressed) addressed_seen = 1'b1;
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_mon();
        we_addr.delete();
        we_data.delete();
        sda_low_seen   = 1'b0;
        addressed_seen = 1'b0;
    endtask

    task automatic i2c_start();
        if (!m_scl) begin
            m_sda = 1'b1; wait_clk(c_Q);
            m_scl = 1'b1; wait_clk(c_Q);
        end
        m_sda = 1'b0; wait_clk(2 * c_Q);
        m_scl = 1'b0; wait_clk(c_Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(c_Q);
        m_scl = 1'b1; wait_clk(c_Q);
        m_sda = 1'b1; wait_clk(2 * c_Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_clk(c_Q);
        m_scl = 1'b1; wait_clk(2 * c_Q);
        m_scl = 1'b0; wait_clk(c_Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clk(c_Q);
        m_scl = 1'b1; wait_clk(c_Q);
        b = bus.sda_in;
        wait_clk(c_Q);
        m_scl = 1'b0; wait_clk(c_Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'hC3;
        mem[8'h40] = 8'h00;

        m_scl = 1'b1;
        m_sda = 1'b1;
        reset = 1'b1;
        clear_mon();
        wait_clk(5);
        check1("rst_sda_low",   bus.sda_low,   1'b0);
        check8("rst_reg_addr",  bus.reg_addr,  8'h00);
        check8("rst_reg_wdata", bus.reg_wdata, 8'h00);
        check1("rst_reg_we",    bus.reg_we,    1'b0);
        check1("rst_busy",      bus.busy,      1'b0);
        check1("rst_addressed", bus.addressed, 1'b0);
        reset = 1'b0;
        wait_clk(20);

        // Write two bytes starting at pointer 0x05
        clear_mon();
        i2c_start();
        check1("wr_busy_after_start", bus.busy, 1'b1);
        write_byte(8'h34, ack); check1("wr_ack_addr", ack, 1'b1);
        check1("wr_addressed", bus.addressed, 1'b1);
        write_byte(8'h05, ack); check1("wr_ack_ptr", ack, 1'b1);
        write_byte(8'hA5, ack); check1("wr_ack_d0", ack, 1'b1);
        write_byte(8'h5A, ack); check1("wr_ack_d1", ack, 1'b1);
        i2c_stop();
        check8("wr_we_count", 8'(we_addr.size()), 8'd2);
        check8("wr_we0_addr", we_addr[0], 8'h05);
        check8("wr_we0_data", we_data[0], 8'hA5);
        check8("wr_we1_addr", we_addr[1], 8'h06);
        check8("wr_we1_data", we_data[1], 8'h5A);
        check8("wr_final_ptr", bus.reg_addr, 8'h07);
        check1("wr_busy_after_stop", bus.busy, 1'b0);
        check1("wr_addressed_after_stop", bus.addressed, 1'b0);

        // Pointer write, repeated START, two-byte read
        clear_mon();
        i2c_start();
        write_byte(8'h34, ack); check1("rd_ack_addr_w", ack, 1'b1);
        write_byte(8'h10, ack); check1("rd_ack_ptr", ack, 1'b1);
        i2c_start();
        write_byte(8'h35, ack); check1("rd_ack_addr_r", ack, 1'b1);
        read_byte(rd, 1'b1);    check8("rd_byte0", rd, 8'h3C);
        read_byte(rd, 1'b0);    check8("rd_byte1", rd, 8'hC3);
        i2c_stop();
        check8("rd_final_ptr", bus.reg_addr, 8'h11);
        check8("rd_we_count", 8'(we_addr.size()), 8'd0);
        check1("rd_busy_after_stop", bus.busy, 1'b0);

        // Another target's address
        clear_mon();
        i2c_start();
        check1("mm_busy", bus.busy, 1'b1);
        write_byte(8'h36, ack); check1("mm_ack_addr", ack, 1'b0);
        write_byte(8'hFF, ack); check1("mm_ack_data", ack, 1'b0);
        i2c_stop();
        check1("mm_sda_never_low", sda_low_seen, 1'b0);
        check1("mm_never_addressed", addressed_seen, 1'b0);
        check8("mm_we_count", 8'(we_addr.size()), 8'd0);
        check1("mm_busy_after_stop", bus.busy, 1'b0);

        // Pointer wrap 0xFF -> 0x00
        clear_mon();
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack); check1("wrap_ack_d0", ack, 1'b1);
        write_byte(8'h22, ack); check1("wrap_ack_d1", ack, 1'b1);
        i2c_stop();
        check8("wrap_we_count", 8'(we_addr.size()), 8'd2);
        check8("wrap_we0_addr", we_addr[0], 8'hFF);
        check8("wrap_we0_data", we_data[0], 8'h11);
        check8("wrap_we1_addr", we_addr[1], 8'h00);
        check8("wrap_we1_data", we_data[1], 8'h22);
        check8("wrap_final_ptr", bus.reg_addr, 8'h01);

        // Short SDA glitch while SCL high is filtered out
        clear_mon();
        m_sda = 1'b0; wait_clk(2);
        m_sda = 1'b1; wait_clk(c_Q);
        check1("glitch_no_start", bus.busy, 1'b0);

        // STOP after four data bits aborts the byte
        clear_mon();
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h20, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        check8("abort_we_count", 8'(we_addr.size()), 8'd0);
        check1("abort_busy", bus.busy, 1'b0);
        check1("abort_addressed", bus.addressed, 1'b0);
        check8("abort_ptr", bus.reg_addr, 8'h20);

        // Reset while the target is driving a read bit low
        clear_mon();
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h40, ack);
        i2c_start();
        write_byte(8'h35, ack);
        check1("rstrd_sda_low_driven", bus.sda_low, 1'b1);
        reset = 1'b1;
        wait_clk(1);
        check1("rstrd_sda_low", bus.sda_low, 1'b0);
        check8("rstrd_reg_addr", bus.reg_addr, 8'h00);
        check1("rstrd_busy", bus.busy, 1'b0);
        check1("rstrd_addressed", bus.addressed, 1'b0);
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
